// File: rtl/hotp_pkg.sv
// Shared types and constants for the HOTP dynamic-truncation reader.
package hotp_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        EXTRACT = 3'd2,
        CONVERT = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int DIGEST_BITS = 160;
    localparam int CONV_STEPS  = 31;
    localparam int OFFSET_LSB  = 128;

    // Big-endian digest byte k taken from the LSB-first word collection.
    function automatic logic [7:0] digest_byte(input logic [159:0] dig, input int k);
        return dig[32*(k/4) + 31 - 8*(k%4) -: 8];
    endfunction

endpackage

// File: rtl/hotp_dabble.sv
// BCD register performing one add-3/shift double-dabble step per enable.
// Carry out of the top digit is dropped, so the result is the value modulo 10^DIGITS.
module hotp_dabble #(
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  bit_in,
    output logic [4*DIGITS-1:0]   bcd
);

    logic [4*DIGITS-1:0] bcd_r;
    logic [4*DIGITS-1:0] adj_s;

    // Add 3 to every digit that is 5 or more ahead of the shift.
    always_comb begin
        adj_s = bcd_r;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_r[4*d +: 4] >= 4'd5) begin
                adj_s[4*d +: 4] = bcd_r[4*d +: 4] + 4'd3;
            end else begin
                adj_s[4*d +: 4] = bcd_r[4*d +: 4];
            end
        end
    end

    // BCD state: reset/clear to zero, otherwise shift in the next binary bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_r <= '0;
        end else if (clr) begin
            bcd_r <= '0;
        end else if (en) begin
            bcd_r <= (adj_s << 1) | {{(4*DIGITS-1){1'b0}}, bit_in};
        end else begin
            bcd_r <= bcd_r;
        end
    end

    assign bcd = bcd_r;

endmodule

// File: rtl/hotp_truncate.sv
// Serial HMAC-SHA-1 digest reader with RFC 4226 dynamic truncation and BCD
// conversion. Optional feature macro: HOTP_TRUNC_RAW_EN exposes the 31-bit
// truncated code on the raw port.
module hotp_truncate
    import hotp_pkg::*;
#(
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    output logic [4*DIGITS-1:0]   digits,
`ifdef HOTP_TRUNC_RAW_EN
    output logic [30:0]           raw,
`endif
    output logic                  valid
);

    state_t          state_r;
    logic [159:0]    dig_r;
    logic [7:0]      bit_cnt_r;
    logic [4:0]      step_cnt_r;
    logic [30:0]     shift_r;
    logic            valid_r;

    logic [7:0]      byte_s [19];
    logic [3:0]      offset_s;
    logic [30:0]     trunc_s;
    logic            dab_clr_s;
    logic            dab_en_s;

    // Digest bytes 0..18; byte 19 only supplies the offset nibble.
    always_comb begin
        for (int k = 0; k < 19; k++) begin
            byte_s[k] = digest_byte(dig_r, k);
        end
        offset_s = dig_r[OFFSET_LSB +: 4];
    end

    // 16-way offset mux; bit 31 of the selected word is masked by omission.
    always_comb begin
        trunc_s = 31'd0;
        for (int k = 0; k < 16; k++) begin
            if (offset_s == 4'(k)) begin
                trunc_s = {byte_s[k][6:0], byte_s[k+1], byte_s[k+2], byte_s[k+3]};
            end else begin
                trunc_s = trunc_s;
            end
        end
    end

    // Dabble control decoded from the current state.
    always_comb begin
        dab_clr_s = (state_r == EXTRACT);
        dab_en_s  = (state_r == CONVERT);
    end

    // Main sequencer: collect, extract, convert, hold; start restarts from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            dig_r      <= 160'd0;
            bit_cnt_r  <= 8'd0;
            step_cnt_r <= 5'd0;
            shift_r    <= 31'd0;
            valid_r    <= 1'b0;
        end else if (start) begin
            state_r    <= COLLECT;
            valid_r    <= 1'b0;
            step_cnt_r <= 5'd0;
            if (bit_valid) begin
                dig_r     <= {bit_in, dig_r[159:1]};
                bit_cnt_r <= 8'd1;
            end else begin
                bit_cnt_r <= 8'd0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= IDLE;
                end
                COLLECT: begin
                    if (bit_valid) begin
                        dig_r <= {bit_in, dig_r[159:1]};
                        if (bit_cnt_r == 8'(DIGEST_BITS - 1)) begin
                            bit_cnt_r <= 8'd0;
                            state_r   <= EXTRACT;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 8'd1;
                        end
                    end
                end
                EXTRACT: begin
                    shift_r    <= trunc_s;
                    step_cnt_r <= 5'd0;
                    state_r    <= CONVERT;
                end
                CONVERT: begin
                    shift_r <= shift_r << 1;
                    if (step_cnt_r == 5'(CONV_STEPS - 1)) begin
                        step_cnt_r <= 5'd0;
                        valid_r    <= 1'b1;
                        state_r    <= DONE;
                    end else begin
                        step_cnt_r <= step_cnt_r + 5'd1;
                    end
                end
                DONE: begin
                    valid_r <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef HOTP_TRUNC_RAW_EN
    logic [30:0] raw_r;

    // Truncated binary code captured alongside the conversion load.
    always_ff @(posedge clk) begin
        if (rst) begin
            raw_r <= 31'd0;
        end else if (!start && state_r == EXTRACT) begin
            raw_r <= trunc_s;
        end else begin
            raw_r <= raw_r;
        end
    end

    assign raw = raw_r;
`endif

    hotp_dabble #(.DIGITS(DIGITS)) u_dabble (
        .clk    (clk),
        .rst    (rst),
        .clr    (dab_clr_s),
        .en     (dab_en_s),
        .bit_in (shift_r[30]),
        .bcd    (digits)
    );

    assign valid = valid_r;

endmodule

// File: tb/tb_hotp_truncate.sv
// Directed bench for hotp_truncate with a scoreboard of expected codes.
// Two instances (DIGITS=6 and DIGITS=8) share the same stimulus.
module tb_hotp_truncate;

    typedef logic [31:0] vec_t [5];

    typedef struct {
        string       tag;
        logic [31:0] d6;
        logic [31:0] d8;
        logic [30:0] raw;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        bit_in;
    logic        bit_valid;
    logic [23:0] digits6;
    logic [31:0] digits8;
    logic        valid6;
    logic        valid8;
`ifdef HOTP_TRUNC_RAW_EN
    logic [30:0] raw6;
    logic [30:0] raw8;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb [$];

    always #5 clk = ~clk;

    hotp_truncate #(.DIGITS(6)) u_dut6 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .digits    (digits6),
`ifdef HOTP_TRUNC_RAW_EN
        .raw       (raw6),
`endif
        .valid     (valid6)
    );

    hotp_truncate #(.DIGITS(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .digits    (digits8),
`ifdef HOTP_TRUNC_RAW_EN
        .raw       (raw8),
`endif
        .valid     (valid8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference truncation straight from the byte-order definition.
    function automatic logic [30:0] model_t(input vec_t w);
        logic [7:0]  b [20];
        logic [31:0] t;
        int          o;
        for (int k = 0; k < 20; k++) begin
            b[k] = w[k/4][31 - 8*(k%4) -: 8];
        end
        o = int'(b[19][3:0]);
        t = {b[o], b[o+1], b[o+2], b[o+3]};
        return t[30:0];
    endfunction

    function automatic logic [31:0] model_bcd(input logic [30:0] t, input int nd);
        longint      m;
        longint      p;
        logic [31:0] r;
        p = 1;
        for (int i = 0; i < nd; i++) p = p * 10;
        m = longint'(t) % p;
        r = 32'd0;
        for (int d = 0; d < nd; d++) begin
            r[4*d +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    // Drive start plus nbits digest bits; optionally idle every third cycle.
    task automatic stream(input vec_t w, input int nbits, input bit gapped);
        int idx;
        int cyc;
        start     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = w[0][0];
        @(negedge clk);
        start = 1'b0;
        check("start_drops_valid6", {31'd0, valid6}, 32'd0);
        idx = 1;
        cyc = 1;
        while (idx < nbits) begin
            cyc++;
            if (gapped && (cyc % 3 == 0)) begin
                bit_valid = 1'b0;
            end else begin
                bit_valid = 1'b1;
                bit_in    = w[idx/32][idx%32];
                idx++;
            end
            @(negedge clk);
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    // Wait (bounded) for valid, then compare latency and scoreboard entry.
    task automatic finish_run();
        int   cnt;
        exp_t e;
        cnt = 0;
        while (valid6 !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("valid_latency", 32'(cnt), 32'd32);
        check("valid8_with_valid6", {31'd0, valid8}, 32'd1);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_digits6"}, {8'd0, digits6}, e.d6);
            check({e.tag, "_digits8"}, digits8, e.d8);
`ifdef HOTP_TRUNC_RAW_EN
            check({e.tag, "_raw6"}, {1'b0, raw6}, {1'b0, e.raw});
            check({e.tag, "_raw8"}, {1'b0, raw8}, {1'b0, e.raw});
`endif
        end
    endtask

    initial begin
        vec_t v1;
        vec_t v2;
        vec_t v3;
        vec_t vr;
        exp_t e;

        v1 = '{32'hcc93cf18, 32'h508d9493, 32'h4c64b65d, 32'h8ba7667f, 32'hb7cde4b0};
        v2 = '{32'h1f869869, 32'h0e02ca16, 32'h618550ef, 32'h7f19da8e, 32'h945b555a};
        v3 = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h000000FF, 32'h1234567F};

        rst = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid6", {31'd0, valid6}, 32'd0);
        check("reset_digits6", {8'd0, digits6}, 32'd0);
        check("reset_valid8", {31'd0, valid8}, 32'd0);
        check("reset_digits8", digits8, 32'd0);
`ifdef HOTP_TRUNC_RAW_EN
        check("reset_raw6", {1'b0, raw6}, 32'd0);
`endif
        rst = 1'b0;

        // bit_valid in IDLE must be ignored
        bit_valid = 1'b1; bit_in = 1'b1;
        repeat (5) @(negedge clk);
        bit_valid = 1'b0; bit_in = 1'b0;
        check("idle_valid", {31'd0, valid6}, 32'd0);

        // RFC 4226 count 0
        e = '{"rfc_cnt0", 32'h00755224, 32'h84755224, 31'h4c93cf18};
        sb.push_back(e);
        stream(v1, 160, 1'b0);
        finish_run();

        // hold in DONE
        repeat (5) @(negedge clk);
        check("hold_valid", {31'd0, valid6}, 32'd1);
        check("hold_digits6", {8'd0, digits6}, 32'h00755224);

        // gapped stream of vector 1
        e = '{"gapped", 32'h00755224, 32'h84755224, 31'h4c93cf18};
        sb.push_back(e);
        stream(v1, 160, 1'b1);
        finish_run();

        // restart in the same cycle valid rose: RFC 4226 example
        e = '{"rfc_ex", 32'h00872921, 32'h57872921, 31'h50ef7f19};
        sb.push_back(e);
        stream(v2, 160, 1'b0);
        finish_run();

        // abort at bit 80, then full vector 2
        stream(v1, 80, 1'b0);
        e = '{"abort_restart", 32'h00872921, 32'h57872921, 31'h50ef7f19};
        sb.push_back(e);
        stream(v2, 160, 1'b0);
        finish_run();

        // offset 15 boundary
        e = '{"offset15", 32'h00899478, 32'h31899478, 31'h7F123456};
        sb.push_back(e);
        stream(v3, 160, 1'b0);
        finish_run();

        // random digests checked against the reference model
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 5; i++) vr[i] = $urandom;
            e.tag = "random";
            e.raw = model_t(vr);
            e.d6  = model_bcd(e.raw, 6);
            e.d8  = model_bcd(e.raw, 8);
            sb.push_back(e);
            stream(vr, 160, (n == 1));
            finish_run();
        end

        // reset in the middle of CONVERT
        stream(v2, 160, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_valid6", {31'd0, valid6}, 32'd0);
        check("midrst_digits6", {8'd0, digits6}, 32'd0);
        check("midrst_digits8", digits8, 32'd0);
`ifdef HOTP_TRUNC_RAW_EN
        check("midrst_raw6", {1'b0, raw6}, 32'd0);
`endif
        repeat (40) @(negedge clk);
        check("midrst_stays_idle", {31'd0, valid6}, 32'd0);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
